// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned MEM_LAT       = 4;
  localparam int unsigned IDX_W         = $clog2(WORDS_PER_BLK);
  // Byte offset bits inside a block: word index plus the byte-in-word bit.
  localparam int unsigned OFS_W         = IDX_W + 1;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One memory-port command, registered as a unit.
  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFS_W) - 1);

  // Align a byte address down to its block base.
  function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
    return a & BLK_MASK;
  endfunction

endpackage

// File: rtl/mem_arb_ctr.sv
// Resettable up-counter with synchronous clear, enable and registered
// terminal-count flag (high while the count equals MAX).
module mem_arb_ctr #(
  parameter int unsigned W   = 3,
  parameter int unsigned MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  // Next count and its terminal flag.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
    tc_d = (cnt_d == W'(MAX));
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the pipelined main memory between I-cache block fills and
// D-cache block fills / write-through stores. Fills issue one address per
// cycle and forward each returned word to the requesting cache.
// Optional build macro: MEM_ARB_RR_EN selects round-robin on I/D ties;
// without it D always beats I.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              fill_valid,
  output logic              fill_sel,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] base_q, base_d;
  mem_cmd_t          mem_q, mem_d;

  logic              iss_clr, iss_en, iss_tc;
  logic              rcv_clr, rcv_en, rcv_tc;
  logic [IDX_W-1:0]  iss_cnt, rcv_cnt;
  logic [ADDR_W-1:0] iss_off;

  logic              d_win, i_win;
  logic              fill_valid_c, last_word_c;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  // On a tie the requester not granted last time wins.
  assign d_win = d_req & (~i_req | (last_q == SEL_I));
`else
  assign d_win = d_req;
`endif
  assign i_win = i_req & ~d_win;

  // Byte offset of the next address to issue (word index + 1, times two).
  assign iss_off = (ADDR_W'(iss_cnt) + ADDR_W'(1)) << 1;

  // Returned words are only accepted while a fill is in progress.
  assign fill_valid_c = (state_q == FILL) & mem_rvalid;
  assign last_word_c  = fill_valid_c & rcv_tc;
  assign rcv_en       = fill_valid_c;

  // Issue counter: index of the address currently on the memory port.
  mem_arb_ctr #(
    .W   (IDX_W),
    .MAX (WORDS_PER_BLK - 1)
  ) u_iss_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (iss_clr),
    .en_i  (iss_en),
    .cnt_o (iss_cnt),
    .tc_o  (iss_tc)
  );

  // Receive counter: index of the next word expected back from memory.
  mem_arb_ctr #(
    .W   (IDX_W),
    .MAX (WORDS_PER_BLK - 1)
  ) u_rcv_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (rcv_clr),
    .en_i  (rcv_en),
    .cnt_o (rcv_cnt),
    .tc_o  (rcv_tc)
  );

  // Next-state, grant latching and next memory command.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    base_d  = base_q;
    mem_d   = '0;
    iss_clr = 1'b0;
    iss_en  = 1'b0;
    rcv_clr = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        iss_clr = 1'b1;
        rcv_clr = 1'b1;
        if (d_win) begin
          sel_d = SEL_D;
`ifdef MEM_ARB_RR_EN
          last_d = SEL_D;
`endif
          if (d_we) begin
            state_d     = WRITE;
            mem_d.en    = 1'b1;
            mem_d.wr    = 1'b1;
            mem_d.addr  = d_addr;
            mem_d.wdata = d_wdata;
          end else begin
            state_d    = FILL;
            base_d     = blk_base(d_addr);
            mem_d.en   = 1'b1;
            mem_d.addr = blk_base(d_addr);
          end
        end else if (i_win) begin
          sel_d = SEL_I;
`ifdef MEM_ARB_RR_EN
          last_d = SEL_I;
`endif
          state_d    = FILL;
          base_d     = blk_base(i_addr);
          mem_d.en   = 1'b1;
          mem_d.addr = blk_base(i_addr);
        end
      end
      FILL: begin
        if (mem_q.en && !iss_tc) begin
          iss_en     = 1'b1;
          mem_d.en   = 1'b1;
          mem_d.addr = base_q + iss_off;
        end
        if (last_word_c) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        state_d = DONE;
      end
      DONE: begin
        iss_clr = 1'b1;
        rcv_clr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered memory command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_I;
      base_q  <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      base_q  <= base_d;
      mem_q   <= mem_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer; starts as "I last" so D takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SEL_I;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign mem_en    = mem_q.en;
  assign mem_wr    = mem_q.wr;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;

  assign fill_valid = fill_valid_c;
  assign fill_sel   = fill_valid_c & sel_q;
  assign fill_idx   = fill_valid_c ? rcv_cnt : '0;
  assign fill_data  = fill_valid_c ? mem_rdata : '0;

  assign i_done = last_word_c & (sel_q == SEL_I);
  assign d_done = (last_word_c & (sel_q == SEL_D)) | (state_q == WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a MEM_LAT-deep read-pipeline memory
// model whose read data is the word address XOR 0x5A5A.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_rvalid;
  logic              fill_valid, fill_sel;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              i_done, d_done;
  logic              stray_rv = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]       pv;
  logic [3:0][15:0] pa;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_valid(fill_valid), .fill_sel(fill_sel), .fill_idx(fill_idx),
    .fill_data(fill_data), .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle t returns in cycle t+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pa <= '0;
    end else begin
      pv <= {pv[2:0], mem_en & ~mem_wr};
      pa <= {pa[2:0], mem_addr};
    end
  end
  assign mem_rvalid = pv[3] | stray_rv;
  assign mem_rdata  = pa[3] ^ 16'h5A5A;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem"}, 32'({mem_en, mem_wr, mem_addr}), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_fill"}, 32'({fill_valid, fill_sel, fill_idx, fill_data}), 32'd0);
    chk({tag, "_done"}, 32'({i_done, d_done}), 32'd0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  // Expected outputs in cycle k of a fill granted in cycle 0.
  task automatic chk_fill_cyc(input int k, input logic sel, input logic [15:0] base);
    logic en, fv;
    logic [15:0] a;
    en = (k >= 1) && (k <= 8);
    fv = (k >= 5) && (k <= 12);
    chk("fill_mem_en", 32'(mem_en), 32'(en));
    chk("fill_mem_wr", 32'(mem_wr), 32'd0);
    if (en) chk("fill_mem_addr", 32'(mem_addr), 32'(base + 16'(2 * (k - 1))));
    chk("fill_valid", 32'(fill_valid), 32'(fv));
    if (fv) begin
      a = base + 16'(2 * (k - 5));
      chk("fill_idx", 32'(fill_idx), 32'(k - 5));
      chk("fill_sel", 32'(fill_sel), 32'(sel));
      chk("fill_data", 32'(fill_data), 32'(a ^ 16'h5A5A));
    end
    chk("fill_i_done", 32'(i_done), 32'((sel == 1'b0) && (k == 12)));
    chk("fill_d_done", 32'(d_done), 32'((sel == 1'b1) && (k == 12)));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(i_done | d_done) && n < 30) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(n < 30), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d;

    // Reset, release, idle, then reset again mid-idle.
    tick(); tick();
    chk_zero("rst_init");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_mem_en", 32'(mem_en), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("rst_idle");
    tick();
    rst_n = 1'b1;
    tick();

    // Plain I fill from 0x1234.
    i_req = 1'b1; i_addr = 16'h1234;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_fill_cyc(k, SEL_I, 16'h1230);
    end
    i_req = 1'b0;
    tick();
    chk("ifill_done_state", 32'(dut.state_q), 32'(DONE));
    chk("ifill_done_en", 32'(mem_en), 32'd0);
    tick();
    chk("ifill_idle_state", 32'(dut.state_q), 32'(IDLE));

    // Simultaneous I and D fills: D first, then I.
    i_req = 1'b1; i_addr = 16'h1234;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0088;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_fill_cyc(k, SEL_D, 16'h0080);
    end
    d_req = 1'b0;
    tick();
    chk("tie_c13_en", 32'(mem_en), 32'd0);
    tick();
    chk("tie_c14_en", 32'(mem_en), 32'd0);
    chk("tie_c14_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("tie_c15_en", 32'(mem_en), 32'd1);
    chk("tie_c15_addr", 32'(mem_addr), 32'h1230);
    wait_done();
    chk("tie_i_done", 32'(i_done), 32'd1);
    i_req = 1'b0;
    tick(); tick();

    // Single-word store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    tick();
    chk("st_mem", 32'({mem_en, mem_wr}), 32'h3);
    chk("st_addr", 32'(mem_addr), 32'h0040);
    chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("st_d_done", 32'(d_done), 32'd1);
    chk("st_i_done", 32'(i_done), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("st_c2_en", 32'(mem_en), 32'd0);
    chk("st_c2_done", 32'(d_done), 32'd0);
    chk("st_c2_state", 32'(dut.state_q), 32'(DONE));
    tick();
    chk("st_c3_state", 32'(dut.state_q), 32'(IDLE));

    // Reset in cycle 6 of an I fill, then restart from word 0.
    i_req = 1'b1; i_addr = 16'h0200;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_fill_cyc(k, SEL_I, 16'h0200);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick();
    chk_zero("rst_hold");
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_fill_cyc(k, SEL_I, 16'h0200);
    end
    i_req = 1'b0;
    tick(); tick();

    // Stray read-valid while idle.
    stray_rv = 1'b1;
    #1;
    chk("stray_fill_valid", 32'(fill_valid), 32'd0);
    chk("stray_done", 32'({i_done, d_done}), 32'd0);
    tick();
    stray_rv = 1'b0;
    chk("stray_state", 32'(dut.state_q), 32'(IDLE));
    chk("stray_mem_en", 32'(mem_en), 32'd0);

    // Back-to-back ties: the winner re-requests as soon as IDLE returns.
    i_addr = 16'h1000; d_addr = 16'h2000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      chk("rr_en", 32'(mem_en), 32'd1);
      chk("rr_addr", 32'(mem_addr), exp_d ? 32'h2000 : 32'h1000);
      wait_done();
      chk("rr_d_done", 32'(d_done), 32'(exp_d));
      chk("rr_i_done", 32'(i_done), 32'(!exp_d));
      if (exp_d) d_req = 1'b0; else i_req = 1'b0;
      tick();
      d_req = 1'b1; i_req = 1'b1;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();
    chk("end_state", 32'(dut.state_q), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
